// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and issue FSM encoding for the alu block and its controller
package alu_pkg;

  localparam int DW   = 32;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  // ALU select codes; OP_LDI never reaches the ALU, the controller consumes it.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL1 = 4'h5;
  localparam logic [3:0] OP_SRL1 = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'hF;

  // Issue FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Immediate loads bypass the ALU entirely.
  function automatic logic op_is_ldi(input logic [3:0] op);
    return op == OP_LDI;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW operand register file, one write port, two operand reads, one debug read
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  // Next register contents: apply the write, then force entry 0 back to zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (we) begin
      rf_d[waddr] = wdata;
    end
    rf_d[0] = '0;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        rf_q[i] <= '0;
      end else begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign rdata1   = rf_q[raddr1];
  assign rdata2   = rf_q[raddr2];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command issue, operand staging and writeback wrapper around the combinational alu
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_o,
  output logic          done,
  output logic [DW-1:0] done_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] rd_q,        rd_d;
  logic [DW-1:0] result_q,    result_d;
  logic [DW-1:0] alu_a_q,     alu_a_d;
  logic [DW-1:0] alu_b_q,     alu_b_d;
  logic [3:0]    alu_s_q,     alu_s_d;
  logic          done_q,      done_d;
  logic [DW-1:0] done_data_q, done_data_d;

  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  // Writeback happens in the WB cycle, so a following accept always sees the new value.
  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (state_q == ST_WB),
    .waddr    (rd_q),
    .wdata    (result_q),
    .raddr1   (cmd_rs1),
    .rdata1   (rs1_data),
    .raddr2   (cmd_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Issue FSM: accept in IDLE, let the ALU settle in EXEC, commit and report in WB.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    result_d    = result_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rd_d = cmd_rd;
          if (op_is_ldi(cmd_op)) begin
            result_d = cmd_imm;
            state_d  = ST_WB;
          end else begin
            alu_a_d = rs1_data;
            alu_b_d = rs2_data;
            alu_s_d = cmd_op;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_o;
        state_d  = ST_WB;
      end
      ST_WB: begin
        done_d      = 1'b1;
        done_data_d = result_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight command without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      result_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= 4'h0;
      done_q      <= 1'b0;
      done_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign done      = done_q;
  assign done_data = done_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural register-file model
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'h0;
  logic [2:0]    cmd_rd = 3'd0;
  logic [2:0]    cmd_rs1 = 3'd0;
  logic [2:0]    cmd_rs2 = 3'd0;
  logic [31:0]   cmd_imm = 32'h0;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [3:0]    alu_s;
  logic [31:0]   alu_o;
  logic          done;
  logic [31:0]   done_data;
  logic [2:0]    dbg_addr = 3'd0;
  logic [31:0]   dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rf_m [8];

  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc [128];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_o     (alu_o),
    .done      (done),
    .done_data (done_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return a << 1;
      4'h6:    return a >> 1;
      4'h7:    return ~a;
      default: return {a[15:0], b[31:16]} ^ {28'h0, s};
    endcase
  endfunction

  assign alu_o = ref_alu(alu_a, alu_b, alu_s);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && cmd_valid && cmd_ready) begin
      if (acc_cnt < 128) acc_cyc[acc_cnt] = cyc;
      acc_cnt = acc_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge, wait for its done pulse and compare with the model.
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [31:0] imm);
    logic [31:0] exp, pa, pb;
    logic [3:0]  ps;
    int k, lat;
    exp = (op == OP_LDI) ? imm : ref_alu(rf_m[rs1], rf_m[rs2], op);
    lat = (op == OP_LDI) ? 2 : 3;
    pa = alu_a; pb = alu_b; ps = alu_s;
    k = 0;
    while (!cmd_ready && k < 8) begin @(negedge clk); k++; end
    check("ready_in_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    dbg_addr = rd;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    check("ready_low_busy", {31'h0, cmd_ready}, 32'h0);
    if (op != OP_LDI) begin
      check("exec_alu_a", alu_a, rf_m[rs1]);
      check("exec_alu_b", alu_b, rf_m[rs2]);
      check("exec_alu_s", {28'h0, alu_s}, {28'h0, op});
    end else begin
      check("ldi_alu_a_hold", alu_a, pa);
      check("ldi_alu_b_hold", alu_b, pb);
      check("ldi_alu_s_hold", {28'h0, alu_s}, {28'h0, ps});
    end
    while (!done && k < 8) begin @(negedge clk); k++; end
    check("done_latency", k, lat);
    check("done_data", done_data, exp);
    if (rd != 3'd0) rf_m[rd] = exp;
    check("dbg_rd_after_wb", dbg_data, rf_m[rd]);
    @(negedge clk);
    check("done_single_pulse", {31'h0, done}, 32'h0);
    check("done_data_hold", done_data, exp);
  endtask

  initial begin
    logic [3:0]  q_op  [3];
    logic [2:0]  q_rd  [3];
    logic [2:0]  q_rs1 [3];
    logic [2:0]  q_rs2 [3];
    logic [31:0] q_exp [3];
    int idx, dn, base;

    for (int i = 0; i < 8; i++) rf_m[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_done_data", done_data, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_s", {28'h0, alu_s}, 32'h0);
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_rf_zero", dbg_data, 32'h0);
    end
    @(negedge clk);

    // Reset in the middle of EXEC aborts the ADD
    run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 32'h0000_00A5);
    run_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 32'h0000_0011);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    dbg_addr = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_exec_alu_a", alu_a, 32'h0000_00A5);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", {31'h0, done}, 32'h0);
    end
    rst = 1'b0;
    check("abort_ready", {31'h0, cmd_ready}, 32'h1);
    check("abort_alu_a", alu_a, 32'h0);
    check("abort_alu_b", alu_b, 32'h0);
    check("abort_r3", dbg_data, 32'h0);
    for (int i = 0; i < 8; i++) rf_m[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("abort_rf_zero", dbg_data, 32'h0);
    end
    @(negedge clk);
    check("abort_no_late_done", {31'h0, done}, 32'h0);

    // Basic arithmetic
    run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 32'h0000_0005);
    run_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 32'h0000_0003);
    run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 32'h0);
    check("add_r3_is_8", rf_m[3], 32'h8);
    run_cmd(OP_SUB, 3'd4, 3'd1, 3'd2, 32'h0);
    check("sub_r4_is_2", rf_m[4], 32'h2);

    // Wrap-around
    run_cmd(OP_LDI, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFFF);
    run_cmd(OP_LDI, 3'd6, 3'd0, 3'd0, 32'h0000_0001);
    run_cmd(OP_ADD, 3'd7, 3'd5, 3'd6, 32'h0);
    check("wrap_r7_is_0", rf_m[7], 32'h0);

    // Write to r0 reports but does not stick
    run_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 32'h0);
    check("r0_done_data", done_data, 32'h8);
    dbg_addr = 3'd0;
    #1;
    check("r0_reads_zero", dbg_data, 32'h0);
    @(negedge clk);

    // Same-register hazard
    run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 32'h0000_00F0);
    run_cmd(OP_AND, 3'd1, 3'd1, 3'd1, 32'h0);
    check("and_r1_unchanged", rf_m[1], 32'h0000_00F0);

    // Held cmd_valid with three dependent commands
    q_op[0] = OP_ADD; q_rd[0] = 3'd4; q_rs1[0] = 3'd1; q_rs2[0] = 3'd3;
    q_op[1] = OP_XOR; q_rd[1] = 3'd5; q_rs1[1] = 3'd4; q_rs2[1] = 3'd1;
    q_op[2] = OP_SUB; q_rd[2] = 3'd6; q_rs1[2] = 3'd5; q_rs2[2] = 3'd4;
    for (int j = 0; j < 3; j++) begin
      q_exp[j] = ref_alu(rf_m[q_rs1[j]], rf_m[q_rs2[j]], q_op[j]);
      if (q_rd[j] != 3'd0) rf_m[q_rd[j]] = q_exp[j];
    end
    base = acc_cnt; idx = 0; dn = 0;
    cmd_op = q_op[0]; cmd_rd = q_rd[0]; cmd_rs1 = q_rs1[0]; cmd_rs2 = q_rs2[0];
    cmd_valid = 1'b1;
    for (int c = 0; c < 24 && (idx < 3 || dn < 3); c++) begin
      @(negedge clk);
      if (acc_cnt - base > idx) begin
        idx = acc_cnt - base;
        if (idx < 3) begin
          cmd_op = q_op[idx]; cmd_rd = q_rd[idx]; cmd_rs1 = q_rs1[idx]; cmd_rs2 = q_rs2[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done) begin
        if (dn < 3) check("b2b_done_data", done_data, q_exp[dn]);
        dn++;
      end
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("b2b_accepts", acc_cnt - base, 3);
    check("b2b_dones", dn, 3);
    check("b2b_gap0", acc_cyc[base + 1] - acc_cyc[base], 3);
    check("b2b_gap1", acc_cyc[base + 2] - acc_cyc[base + 1], 3);
    for (int j = 0; j < 3; j++) begin
      dbg_addr = q_rd[j];
      #1;
      check("b2b_rf", dbg_data, rf_m[q_rd[j]]);
    end
    @(negedge clk);

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? OP_LDI : 4'($urandom_range(0, 14));
      run_cmd(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("final_rf", dbg_data, rf_m[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
